// File: rtl/common_types_pkg.sv
// Shared types for the core memory path: RAM sequencing states and arbiter grant codes.
// Also holds the widths for the unified RAM port.
package common_types_pkg;

  typedef enum logic [1:0] {
    RAM_IDLE,
    RAM_WAIT,
    RAM_DONE
  } ram_state_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_I,
    GRANT_D
  } arb_grant_t;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_STRB_W = 4;

  // Instruction fetch always reads a full word.
  function automatic logic [MEM_STRB_W-1:0] fetch_strobe();
    return {MEM_STRB_W{1'b1}};
  endfunction

endpackage

// File: rtl/arbiter_grant_sel.sv
// Combinational grant select between fetch and data requesters; zero latency, no state.
// ARBITER_RR_EN selects round-robin on contention, otherwise data always wins.
module arbiter_grant_sel
  import common_types_pkg::*;
(
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  arb_grant_t last_grant_i,
  output arb_grant_t grant_o
);

`ifdef ARBITER_RR_EN
  always_comb begin
    grant_o = GRANT_NONE;
    if (i_req_i && d_req_i) begin
      grant_o = (last_grant_i == GRANT_D) ? GRANT_I : GRANT_D;
    end else if (d_req_i) begin
      grant_o = GRANT_D;
    end else if (i_req_i) begin
      grant_o = GRANT_I;
    end
  end
`else
  // Fixed priority has no use for the grant history.
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant_i;

  always_comb begin
    grant_o = GRANT_NONE;
    if (d_req_i) begin
      grant_o = GRANT_D;
    end else if (i_req_i) begin
      grant_o = GRANT_I;
    end
  end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Shares one RAM port between fetch (read) and data (load/store); one transaction in flight,
// ready pulses 2 cycles after grant plus RAM wait cycles. Optional macro: ARBITER_RR_EN.
module memory_arbiter
  import common_types_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int STRB_W = MEM_STRB_W
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                i_ren,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [STRB_W*8-1:0] i_rdata,
  output logic                i_ready,
  input  logic                d_ren,
  input  logic                d_wen,
  input  logic [STRB_W-1:0]   d_strobe,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [STRB_W*8-1:0] d_wdata,
  output logic [STRB_W*8-1:0] d_rdata,
  output logic                d_ready,
  output logic                ram_ren,
  output logic                ram_wen,
  output logic [STRB_W-1:0]   ram_strobe,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [STRB_W*8-1:0] ram_wdata,
  input  logic [STRB_W*8-1:0] ram_rdata,
  input  logic                ram_ready
);

  localparam int WORD_W = STRB_W * 8;

  ram_state_t          state_q, state_d;
  arb_grant_t          grant_q, grant_d;
  arb_grant_t          sel_grant;
  arb_grant_t          last_grant;
  logic                ram_ren_q, ram_ren_d;
  logic                ram_wen_q, ram_wen_d;
  logic [STRB_W-1:0]   ram_strobe_q, ram_strobe_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [WORD_W-1:0]   i_rdata_q, i_rdata_d;
  logic [WORD_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_ready_q, i_ready_d;
  logic                d_ready_q, d_ready_d;

  arbiter_grant_sel u_grant_sel (
    .i_req_i      (i_ren),
    .d_req_i      (d_ren | d_wen),
    .last_grant_i (last_grant),
    .grant_o      (sel_grant)
  );

`ifdef ARBITER_RR_EN
  arb_grant_t last_grant_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      last_grant_q <= GRANT_I;
    end else if (state_q == RAM_IDLE && sel_grant != GRANT_NONE) begin
      last_grant_q <= sel_grant;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = GRANT_I;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ram_ren_d    = ram_ren_q;
    ram_wen_d    = ram_wen_q;
    ram_strobe_d = ram_strobe_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;

    case (state_q)
      RAM_IDLE: begin
        if (sel_grant == GRANT_D) begin
          grant_d      = GRANT_D;
          state_d      = RAM_WAIT;
          ram_addr_d   = d_addr;
          ram_wdata_d  = d_wdata;
          ram_strobe_d = d_strobe;
          // A simultaneous read+write request resolves to the write.
          ram_wen_d    = d_wen;
          ram_ren_d    = !d_wen;
        end else if (sel_grant == GRANT_I) begin
          grant_d      = GRANT_I;
          state_d      = RAM_WAIT;
          ram_addr_d   = i_addr;
          ram_strobe_d = fetch_strobe();
          ram_wen_d    = 1'b0;
          ram_ren_d    = 1'b1;
        end
      end
      RAM_WAIT: begin
        if (ram_ready) begin
          state_d   = RAM_DONE;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          if (grant_q == GRANT_I) begin
            i_rdata_d = ram_rdata;
            i_ready_d = 1'b1;
          end else if (grant_q == GRANT_D) begin
            if (ram_ren_q) begin
              d_rdata_d = ram_rdata;
            end
            d_ready_d = 1'b1;
          end
        end
      end
      RAM_DONE: begin
        state_d = RAM_IDLE;
        grant_d = GRANT_NONE;
      end
      default: begin
        state_d = RAM_IDLE;
        grant_d = GRANT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= RAM_IDLE;
      grant_q      <= GRANT_NONE;
      ram_ren_q    <= 1'b0;
      ram_wen_q    <= 1'b0;
      ram_strobe_q <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ram_ren_q    <= ram_ren_d;
      ram_wen_q    <= ram_wen_d;
      ram_strobe_q <= ram_strobe_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
    end
  end

  assign ram_ren    = ram_ren_q;
  assign ram_wen    = ram_wen_q;
  assign ram_strobe = ram_strobe_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign i_ready    = i_ready_q;
  assign d_ready    = d_ready_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: requester agents push expected results, a monitor
// pops and compares on every ready pulse and RAM access start; a RAM model answers with random latency.
module tb_memory_arbiter;
  import common_types_pkg::*;

`ifdef ARBITER_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk, nrst;
  logic        i_ren, i_ready, d_ren, d_wen, d_ready;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_strobe, ram_strobe;
  logic        ram_ren, ram_wen, ram_ready;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  memory_arbiter dut (
    .clk(clk), .nrst(nrst),
    .i_ren(i_ren), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_ren(d_ren), .d_wen(d_wen), .d_strobe(d_strobe), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_strobe(ram_strobe), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        fq[$];
  exp_t        dq[$];
  arb_grant_t  grant_log[$];
  int          d_rdy_cyc[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] ram_mem[logic [31:0]];
  logic [31:0] d_hold;

  int n_cmp = 0, n_err = 0;
  int cyc_cnt = 0, n_starts = 0, last_txn_len = 0;
  int lat_fix = 0;
  bit spur_en = 0, spur_always = 0, mon_en = 0;
  arb_grant_t model_last = GRANT_I;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : mem_init(a);
  endfunction

  // RAM model: random or fixed response latency, optional spurious ready when idle.
  initial begin : ram_model
    bit busy;
    int cnt;
    busy = 0; cnt = 0; ram_ready = 1'b0; ram_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (ram_ren || ram_wen) begin
        if (!busy) begin
          busy = 1;
          cnt  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
        end
        if (cnt == 0) begin
          ram_ready = 1'b1;
          busy = 0;
          if (ram_wen) begin
            ram_mem[ram_addr] = merge(ram_rd(ram_addr), ram_wdata, ram_strobe);
            ram_rdata = $urandom;
          end else begin
            ram_rdata = ram_rd(ram_addr);
          end
        end else begin
          cnt--;
          ram_ready = 1'b0;
          ram_rdata = $urandom;
        end
      end else begin
        busy = 0;
        ram_ready = spur_always || (spur_en && $urandom_range(0, 3) == 0);
        ram_rdata = $urandom;
      end
    end
  end

  // Monitor: expected grantee from the requests seen in the idle cycle, ready one cycle after handshake.
  initial begin : monitor
    bit strb_prev, hs_prev, prev_ireq, prev_dreq, strb_now, hs_now;
    arb_grant_t own, p;
    exp_t e;
    logic [69:0] snap, cur;
    int txn_len;
    strb_prev = 0; hs_prev = 0; prev_ireq = 0; prev_dreq = 0;
    own = GRANT_NONE; snap = '0; txn_len = 0;
    forever begin
      @(negedge clk);
      strb_now = ram_ren || ram_wen;
      hs_now   = strb_now && ram_ready;
      cur      = {ram_ren, ram_wen, ram_strobe, ram_addr, ram_wdata};
      if (mon_en) begin
        chk("i_ready_timing", {31'b0, i_ready}, {31'b0, hs_prev && own == GRANT_I});
        chk("d_ready_timing", {31'b0, d_ready}, {31'b0, hs_prev && own == GRANT_D});
        if (i_ready) begin
          if (fq.size() == 0) begin
            chk("i_ready_unexpected", 32'd1, 32'd0);
          end else begin
            e = fq.pop_front();
            chk("i_rdata", i_rdata, e.rdata);
          end
        end
        if (d_ready) begin
          d_rdy_cyc.push_back(cyc_cnt);
          if (dq.size() == 0) begin
            chk("d_ready_unexpected", 32'd1, 32'd0);
          end else begin
            e = dq.pop_front();
            chk("d_rdata", d_rdata, e.rdata);
          end
        end
        if (strb_now && !strb_prev) begin
          n_starts++;
          txn_len = 0;
          snap = cur;
          if (prev_dreq && prev_ireq) p = (RR_EN && model_last == GRANT_D) ? GRANT_I : GRANT_D;
          else if (prev_dreq) p = GRANT_D;
          else if (prev_ireq) p = GRANT_I;
          else p = GRANT_NONE;
          own = p;
          grant_log.push_back(p);
          if (p == GRANT_NONE) begin
            chk("grant_without_request", 32'd1, 32'd0);
          end else if ((p == GRANT_I && fq.size() == 0) || (p == GRANT_D && dq.size() == 0)) begin
            chk("duplicate_grant", 32'd1, 32'd0);
          end else begin
            model_last = p;
            e = (p == GRANT_I) ? fq[0] : dq[0];
            chk("ram_addr", ram_addr, e.addr);
            chk("ram_strobe", {28'b0, ram_strobe}, {28'b0, e.strb});
            chk("ram_wen", {31'b0, ram_wen}, {31'b0, e.wr});
            chk("ram_ren", {31'b0, ram_ren}, {31'b0, !e.wr});
            if (e.wr) chk("ram_wdata", ram_wdata, e.wdata);
          end
        end else if (strb_now) begin
          chk("ram_hold", {31'b0, cur == snap}, 32'd1);
        end
        if (strb_now) txn_len++;
        if (hs_now) last_txn_len = txn_len;
        hs_prev = hs_now;
      end else begin
        hs_prev = 0;
        model_last = GRANT_I;
      end
      strb_prev = strb_now;
      prev_ireq = i_ren;
      prev_dreq = d_ren || d_wen;
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after ready, request dropped.
  task automatic do_fetch(input logic [31:0] a, output int lat);
    exp_t e;
    int c;
    e.wr = 1'b0; e.addr = a; e.strb = 4'hF; e.wdata = '0; e.rdata = ref_rd(a);
    fq.push_back(e);
    i_ren = 1'b1; i_addr = a;
    c = 0;
    forever begin
      @(negedge clk);
      if (i_ready) break;
      c++;
      if (c > 60) begin
        chk("fetch_timeout", 32'd1, 32'd0);
        break;
      end
    end
    lat = c;
    @(posedge clk); #1;
    i_ren = 1'b0;
  endtask

  task automatic do_data(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] wd, output int lat);
    exp_t e;
    int c;
    e.wr = wr; e.addr = a; e.strb = s; e.wdata = wd;
    if (wr) begin
      ref_mem[a] = merge(ref_rd(a), wd, s);
      e.rdata = d_hold;
    end else begin
      e.rdata = ref_rd(a);
      d_hold = e.rdata;
    end
    dq.push_back(e);
    d_ren = rd; d_wen = wr; d_addr = a; d_strobe = s; d_wdata = wd;
    c = 0;
    forever begin
      @(negedge clk);
      if (d_ready) break;
      c++;
      if (c > 60) begin
        chk("data_timeout", 32'd1, 32'd0);
        break;
      end
    end
    lat = c;
    @(posedge clk); #1;
    d_ren = 1'b0; d_wen = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ctrl"}, {25'b0, ram_ren, ram_wen, ram_strobe, i_ready, d_ready}, 32'd0);
    chk({tag, "_ram_addr"}, ram_addr, 32'd0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    chk({tag, "_i_rdata"}, i_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : stimulus
    int lat, lat2, base, starts0, gl0, c;
    arb_grant_t exp_first;
    nrst = 1'b0; i_ren = 0; i_addr = '0; d_ren = 0; d_wen = 0;
    d_strobe = '0; d_addr = '0; d_wdata = '0; d_hold = '0;
    ref_mem[32'h100] = 32'h00A0_0093;
    ram_mem[32'h100] = 32'h00A0_0093;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    nrst = 1'b1; mon_en = 1;

    // Fetch only, immediate RAM response.
    lat_fix = 0;
    do_fetch(32'h100, lat);
    chk("fetch_latency", lat, 2);

    // Store with two extra RAM wait cycles.
    lat_fix = 2;
    do_data(1'b0, 1'b1, 32'h2004, 4'h3, 32'hDEAD_BEEF, lat);
    chk("store_latency", lat, 4);
    chk("store_wen_cycles", last_txn_len, 3);

    // Contention: both requests in the same idle cycle.
    lat_fix = 0;
    exp_first = (RR_EN && model_last == GRANT_D) ? GRANT_I : GRANT_D;
    gl0 = grant_log.size();
    fork
      do_fetch(32'h200, lat);
      do_data(1'b1, 1'b0, 32'h2004, 4'hF, 32'h0, lat2);
    join
    chk("contention_grants", grant_log.size() - gl0, 2);
    if (grant_log.size() >= gl0 + 2) begin
      chk("contention_first", {30'b0, grant_log[gl0]}, {30'b0, exp_first});
      chk("contention_second", {30'b0, grant_log[gl0 + 1]},
          {30'b0, (exp_first == GRANT_D) ? GRANT_I : GRANT_D});
    end

    // Back-to-back loads with immediate RAM response.
    d_rdy_cyc.delete();
    starts0 = n_starts;
    for (int k = 0; k < 4; k++) do_data(1'b1, 1'b0, 32'h2000 + 32'(4 * k), 4'hF, 32'h0, lat);
    chk("b2b_ready_count", d_rdy_cyc.size(), 4);
    chk("b2b_ram_starts", n_starts - starts0, 4);
    for (int k = 1; k < d_rdy_cyc.size(); k++)
      chk("b2b_spacing", d_rdy_cyc[k] - d_rdy_cyc[k-1], 3);

    // Spurious ram_ready while idle, then an illegal read+write request.
    spur_always = 1;
    repeat (6) @(posedge clk);
    #1;
    lat_fix = 1;
    do_data(1'b1, 1'b1, 32'h2008, 4'hC, 32'h1234_ABCD, lat);
    chk("illegal_latency", lat, 3);
    repeat (3) @(posedge clk);
    #1;
    spur_always = 0;

    // Randomized concurrent traffic.
    lat_fix = -1; spur_en = 1;
    fork
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #0;
        do_fetch(32'(4 * $urandom_range(0, 1023)), lat);
      end
      for (int k = 0; k < 40; k++) begin
        int r;
        int l2;
        r = $urandom_range(0, 9);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #0;
        do_data(r > 4 || r == 0, r <= 4, 32'h2000 + 32'(4 * $urandom_range(0, 15)),
                4'($urandom), $urandom, l2);
      end
    join
    spur_en = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("queues_drained", fq.size() + dq.size(), 0);

    // Reset while a load waits on the RAM.
    mon_en = 0; lat_fix = 8;
    d_ren = 1'b1; d_addr = 32'h2020; d_strobe = 4'hF;
    c = 0;
    forever begin
      @(negedge clk);
      if (ram_ren) break;
      c++;
      if (c > 10) begin
        chk("reset_test_ren_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    nrst = 1'b0; d_ren = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midwait_reset");
    base = 0;
    repeat (6) begin
      @(negedge clk);
      if (i_ready || d_ready) base++;
    end
    chk("no_ready_after_reset", base, 0);
    fq.delete(); dq.delete(); d_hold = '0;
    @(posedge clk); #1;
    lat_fix = 0; mon_en = 1;
    do_data(1'b1, 1'b0, 32'h2020, 4'hF, 32'h0, lat);
    chk("post_reset_latency", lat, 2);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
